dmni_br_receiver: RTL and testbench

- Receive-side buffer between the BrLite broadcast router port and the DMNI memory-mapped register file.
- Accepts broadcast payload records over a valid/ack handshake and stores them in a FIFO.
- Software reads the head record through DMNI_BR_KSVC (0x40, peek) and DMNI_BR_PAYLOAD (0x44, pop).
- Raises an interrupt request while the FIFO is non-empty.

---
 rtl/dmni_br_receiver_if.sv | 37 +++
 rtl/dmni_br_receiver.sv | 128 ++++++++++++
 tb/tb_dmni_br_receiver.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmni_br_receiver_if.sv
// BrLite receive port and DMNI MMR access bundle for dmni_br_receiver.
// slave modport is the receiver side, master modport the driver side.
interface dmni_br_receiver_if;
    logic        br_req_i;
    logic        br_ack_o;
    logic [35:0] br_payload_i;
    logic        cfg_en_i;
    logic        cfg_we_i;
    logic [7:0]  cfg_addr_i;
    logic [31:0] cfg_data_i;
    logic [31:0] cfg_data_o;
    logic        cfg_hit_o;

    modport slave (
        input  br_req_i,
        input  br_payload_i,
        input  cfg_en_i,
        input  cfg_we_i,
        input  cfg_addr_i,
        input  cfg_data_i,
        output br_ack_o,
        output cfg_data_o,
        output cfg_hit_o
    );

    modport master (
        output br_req_i,
        output br_payload_i,
        output cfg_en_i,
        output cfg_we_i,
        output cfg_addr_i,
        output cfg_data_i,
        input  br_ack_o,
        input  cfg_data_o,
        input  cfg_hit_o
    );
endinterface

// File: rtl/dmni_br_receiver.sv
// BrLite broadcast receive FIFO with DMNI peek/pop registers and IRQ.
// Optional macro DMNI_BR_DROP_EN: drop records when full, sticky overflow.
module dmni_br_receiver #(
    parameter int BUFFER_SIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    dmni_br_receiver_if.slave   bus,
    output logic                irq_o,
    output logic                overflow_o
);
    localparam int            PW          = $clog2(BUFFER_SIZE);
    localparam logic [PW:0]   DEPTH       = (PW+1)'(BUFFER_SIZE);
    localparam logic [7:0]    ADDR_KSVC   = 8'h40;
    localparam logic [7:0]    ADDR_PAYLOAD = 8'h44;

    typedef struct packed {
        logic [15:0] payload;
        logic [15:0] seq_source;
        logic [3:0]  ksvc;
    } br_payload_t;

    br_payload_t   mem [BUFFER_SIZE];
    br_payload_t   head;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic [PW:0]   count_nxt;
    logic          full;
    logic          empty;
    logic          rd;
    logic          peek;
    logic          pop_req;
    logic          pop;
    logic          push;
    logic          clr;
    logic          unused_wdata;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign head    = mem[rptr];

    assign rd      = bus.cfg_en_i && !bus.cfg_we_i;
    assign peek    = rd && (bus.cfg_addr_i == ADDR_KSVC);
    assign pop_req = rd && (bus.cfg_addr_i == ADDR_PAYLOAD);
    assign pop     = pop_req && !empty;

    // Writes only ever act as a strobe; the data itself is meaningless here.
    assign unused_wdata = ^bus.cfg_data_i;

`ifdef DMNI_BR_DROP_EN
    logic drop;

    assign bus.br_ack_o = 1'b1;
    assign push = bus.br_req_i && !full;
    assign drop = bus.br_req_i && full;
    assign clr  = bus.cfg_en_i && bus.cfg_we_i
                  && (bus.cfg_addr_i == ADDR_KSVC);

    // Sticky drop flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (clr) begin
            overflow_o <= 1'b0;
        end
    end
`else
    assign bus.br_ack_o = !full;
    assign push = bus.br_req_i && !full;
    assign clr  = 1'b0;
    assign overflow_o = 1'b0;
`endif

    // Record storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr] <= bus.br_payload_i;
        end
    end

    // Occupancy after this edge from the push/pop pair.
    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Pointers, count and the non-empty interrupt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            irq_o <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count_nxt;
            irq_o <= (count_nxt != '0);
        end
    end

    // Registered MMR read data and decode hit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.cfg_data_o <= '0;
            bus.cfg_hit_o  <= 1'b0;
        end else begin
            bus.cfg_hit_o <= peek || pop_req || clr;
            if (peek) begin
                bus.cfg_data_o <= empty ? '0 : {28'b0, head.ksvc};
            end else if (pop_req) begin
                bus.cfg_data_o <= empty ? '0
                                  : {head.seq_source, head.payload};
            end
        end
    end
endmodule

// File: tb/tb_dmni_br_receiver.sv
// Self-checking bench for dmni_br_receiver against a queue-based model.
// Build with +define+DMNI_BR_DROP_EN to exercise the drop variant.
module tb_dmni_br_receiver;
    localparam int N = 8;
`ifdef DMNI_BR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic irq_o;
    logic overflow_o;

    dmni_br_receiver_if bus ();

    dmni_br_receiver #(.BUFFER_SIZE(N)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bus        (bus.slave),
        .irq_o      (irq_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [35:0] q[$];
    logic [31:0] exp_data = '0;
    logic        exp_hit = 1'b0;
    logic        exp_ovf = 1'b0;
    logic        exp_ack = 1'b1;
    logic        ack_seen;

    function automatic logic [35:0] mk(input logic [15:0] p,
                                       input logic [15:0] s,
                                       input logic [3:0] k);
        return {p, s, k};
    endfunction

    // Drive one cycle of stimulus and advance the model to the edge.
    task automatic step(input logic req, input logic [35:0] rec,
                        input logic en, input logic we,
                        input logic [7:0] addr);
        bit was_full;
        bus.br_req_i     = req;
        bus.br_payload_i = rec;
        bus.cfg_en_i     = en;
        bus.cfg_we_i     = we;
        bus.cfg_addr_i   = addr;
        bus.cfg_data_i   = $urandom;
        was_full = (q.size() == N);
        exp_ack  = DROP || !was_full;
        #3;
        ack_seen = bus.br_ack_o;
        exp_hit  = 1'b0;
        if (en && !we && addr == 8'h40) begin
            exp_hit  = 1'b1;
            exp_data = (q.size() != 0) ? {28'b0, q[0][3:0]} : 32'b0;
        end else if (en && !we && addr == 8'h44) begin
            exp_hit = 1'b1;
            if (q.size() != 0) begin
                exp_data = {q[0][19:4], q[0][35:20]};
                void'(q.pop_front());
            end else begin
                exp_data = 32'b0;
            end
        end else if (DROP && en && we && addr == 8'h40) begin
            exp_hit = 1'b1;
            exp_ovf = 1'b0;
        end
        if (req && !was_full) q.push_back(rec);
        else if (req && DROP) exp_ovf = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 36'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic drain();
        for (int i = 0; i < N + 2; i++) step(1'b0, 36'b0, 1'b1, 1'b0, 8'h44);
    endtask

    task automatic test_reset();
        bus.br_req_i = 0; bus.br_payload_i = 0; bus.cfg_en_i = 0;
        bus.cfg_we_i = 0; bus.cfg_addr_i = 0; bus.cfg_data_i = 0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (bus.cfg_data_o !== 32'h0 || bus.cfg_hit_o !== 1'b0 ||
            irq_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset got data=%h hit=%b irq=%b ovf=%b exp 0 0 0 0",
                     bus.cfg_data_o, bus.cfg_hit_o, irq_o, overflow_o);
        end
        rst_ni = 1'b1;
        #1;
        checks++;
        if (bus.br_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ack got %b exp 1", bus.br_ack_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_single();
        step(1'b1, mk(16'hBEEF, 16'h0102, 4'h3), 1'b0, 1'b0, 8'h00);
        checks++;
        if (ack_seen !== 1'b1 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL single_push got ack=%b irq=%b exp 1 1", ack_seen, irq_o);
        end
        step(1'b0, 36'b0, 1'b1, 1'b0, 8'h40);
        checks++;
        if (bus.cfg_data_o !== 32'h3 || bus.cfg_hit_o !== 1'b1 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL single_peek got %h hit=%b irq=%b exp 00000003 1 1",
                     bus.cfg_data_o, bus.cfg_hit_o, irq_o);
        end
        step(1'b0, 36'b0, 1'b1, 1'b0, 8'h44);
        checks++;
        if (bus.cfg_data_o !== 32'h0102BEEF || bus.cfg_hit_o !== 1'b1 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL single_pop got %h hit=%b irq=%b exp 0102beef 1 0",
                     bus.cfg_data_o, bus.cfg_hit_o, irq_o);
        end
        idle();
        checks++;
        if (bus.cfg_hit_o !== 1'b0 || bus.cfg_data_o !== 32'h0102BEEF) begin
            errors++;
            $display("FAIL idle_hold got %h hit=%b exp 0102beef 0",
                     bus.cfg_data_o, bus.cfg_hit_o);
        end
    endtask

    task automatic test_fill();
        logic [35:0] extra;
        for (int i = 1; i <= N; i++)
            step(1'b1, mk(16'(i), 16'(i + 256), 4'(i)), 1'b0, 1'b0, 8'h00);
`ifdef DMNI_BR_DROP_EN
        extra = mk(16'h0009, 16'h0109, 4'hA);
        step(1'b1, extra, 1'b0, 1'b0, 8'h00);
        checks++;
        if (ack_seen !== 1'b1 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL drop_full got ack=%b ovf=%b exp 1 1", ack_seen, overflow_o);
        end
        for (int i = 1; i <= N; i++) begin
            step(1'b0, 36'b0, 1'b1, 1'b0, 8'h44);
            checks++;
            if (bus.cfg_data_o !== {16'(i + 256), 16'(i)}) begin
                errors++;
                $display("FAIL drop_order got %h exp %h", bus.cfg_data_o,
                         {16'(i + 256), 16'(i)});
            end
        end
        checks++;
        if (irq_o !== 1'b0 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL drop_absent got irq=%b ovf=%b exp 0 1", irq_o, overflow_o);
        end
        step(1'b0, 36'b0, 1'b1, 1'b1, 8'h40);
        checks++;
        if (overflow_o !== 1'b0 || bus.cfg_hit_o !== 1'b1) begin
            errors++;
            $display("FAIL drop_clear got ovf=%b hit=%b exp 0 1", overflow_o, bus.cfg_hit_o);
        end
`else
        extra = mk(16'h0009, 16'h0109, 4'h9);
        step(1'b1, extra, 1'b0, 1'b0, 8'h00);
        checks++;
        if (ack_seen !== 1'b0) begin
            errors++;
            $display("FAIL full_ack got %b exp 0", ack_seen);
        end
        step(1'b1, extra, 1'b1, 1'b0, 8'h44);
        checks++;
        if (ack_seen !== 1'b0 || bus.cfg_data_o !== 32'h0101_0001) begin
            errors++;
            $display("FAIL full_pop got ack=%b data=%h exp 0 01010001",
                     ack_seen, bus.cfg_data_o);
        end
        step(1'b1, extra, 1'b0, 1'b0, 8'h00);
        checks++;
        if (ack_seen !== 1'b1) begin
            errors++;
            $display("FAIL unfull_ack got %b exp 1", ack_seen);
        end
        for (int i = 2; i <= N + 1; i++) begin
            step(1'b0, 36'b0, 1'b1, 1'b0, 8'h44);
            checks++;
            if (bus.cfg_data_o !== {16'(i + 256), 16'(i)}) begin
                errors++;
                $display("FAIL wrap_order got %h exp %h", bus.cfg_data_o,
                         {16'(i + 256), 16'(i)});
            end
        end
        checks++;
        if (irq_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_empty got irq=%b ovf=%b exp 0 0", irq_o, overflow_o);
        end
`endif
    endtask

    task automatic test_empty_pop();
        step(1'b0, 36'b0, 1'b1, 1'b0, 8'h44);
        checks++;
        if (bus.cfg_data_o !== 32'h0 || bus.cfg_hit_o !== 1'b1 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_pop got %h hit=%b irq=%b exp 0 1 0",
                     bus.cfg_data_o, bus.cfg_hit_o, irq_o);
        end
        step(1'b1, mk(16'h1234, 16'h5678, 4'h5), 1'b1, 1'b0, 8'h44);
        checks++;
        if (bus.cfg_data_o !== 32'h0 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL push_cycle_read got %h irq=%b exp 0 1", bus.cfg_data_o, irq_o);
        end
        step(1'b0, 36'b0, 1'b1, 1'b0, 8'h44);
        checks++;
        if (bus.cfg_data_o !== 32'h5678_1234 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL after_empty got %h irq=%b exp 56781234 0", bus.cfg_data_o, irq_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] rec;
        for (int i = 0; i < 4; i++) step(1'b1, {$urandom, 4'($urandom)}, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            rec = {$urandom, 4'($urandom)};
            step(1'b1, rec, 1'b1, 1'b0, 8'h44);
            checks++;
            if (ack_seen !== 1'b1 || bus.cfg_data_o !== exp_data || irq_o !== 1'b1) begin
                errors++;
                $display("FAIL stream got ack=%b data=%h irq=%b exp 1 %h 1",
                         ack_seen, bus.cfg_data_o, irq_o, exp_data);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 36'b0, 1'b1, 1'b0, 8'h44);
            checks++;
            if (bus.cfg_data_o !== exp_data || irq_o !== (q.size() != 0)) begin
                errors++;
                $display("FAIL stream_drain got %h irq=%b exp %h %b",
                         bus.cfg_data_o, irq_o, exp_data, q.size() != 0);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] addrs [4];
        addrs = '{8'h40, 8'h44, 8'h48, 8'h00};
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, 4'($urandom)},
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 addrs[$urandom_range(0, 3)]);
            checks++;
            if (ack_seen !== exp_ack || bus.cfg_data_o !== exp_data ||
                bus.cfg_hit_o !== exp_hit || irq_o !== (q.size() != 0) ||
                overflow_o !== exp_ovf) begin
                errors++;
                $display("FAIL random[%0d] got ack=%b d=%h hit=%b irq=%b ovf=%b exp %b %h %b %b %b",
                         i, ack_seen, bus.cfg_data_o, bus.cfg_hit_o, irq_o, overflow_o,
                         exp_ack, exp_data, exp_hit, q.size() != 0, exp_ovf);
            end
        end
        drain();
        step(1'b0, 36'b0, 1'b1, 1'b1, 8'h40);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, mk(16'(i + 1), 16'hA5A5, 4'h7), 1'b0, 1'b0, 8'h00);
        step(1'b0, 36'b0, 1'b1, 1'b0, 8'h40);
        checks++;
        if (bus.cfg_data_o !== 32'h7 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got %h irq=%b exp 00000007 1", bus.cfg_data_o, irq_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (irq_o !== 1'b0 || bus.cfg_data_o !== 32'h0 || bus.cfg_hit_o !== 1'b0 ||
            overflow_o !== 1'b0 || bus.br_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got irq=%b d=%h hit=%b ovf=%b ack=%b exp 0 0 0 0 1",
                     irq_o, bus.cfg_data_o, bus.cfg_hit_o, overflow_o, bus.br_ack_o);
        end
        q.delete();
        exp_data = '0;
        exp_ovf  = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(1'b0, 36'b0, 1'b1, 1'b0, 8'h44);
        checks++;
        if (bus.cfg_data_o !== 32'h0 || bus.cfg_hit_o !== 1'b1 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_read got %h hit=%b irq=%b exp 0 1 0",
                     bus.cfg_data_o, bus.cfg_hit_o, irq_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_empty_pop();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
